ram16x4_arbiter: RTL and testbench
==================================

// Module: ram16x4_arbiter
// PURPOSE
//   Shares the playground's single-port 16x4 synchronous RAM between two requesters:
//     - requester 0: pin-side access (RAM mode).
//     - requester 1: on-chip client, e.g. a pattern/self-test engine.
//   Each request is accepted via a valid/ready handshake and arbitrated round-robin.
//   The accepted request is sequenced onto the RAM port. Read data or a write acknowledge
//   is returned to the winning requester only.
// PARAMETERS
//   AW          4   RAM address width (16 words)
//   DW          4   RAM data width
//   FIXED_PRIO  0   1 = requester 0 always wins ties; 0 = round-robin
// PORTS
//   clk         in   1   system clock, all logic on rising edge
//   rst         in   1   synchronous reset, active-high
//   req_valid   in   2   per-requester request valid (bit i = requester i)
//   req_we      in   2   per-requester write enable (1 = write, 0 = read)
//   req_addr    in   2*AW  {addr1, addr0}
//   req_wdata   in   2*DW  {wdata1, wdata0}
//   req_ready   out  2   one-hot accept pulse; request i taken when valid[i] & ready[i]
//   rsp_valid   out  2   one-hot completion pulse (read data valid or write done)
//   rsp_rdata   out  DW  read data, valid when rsp_valid!=0 for a read, else 0
//   ram_we      out  1   RAM write enable
//   ram_addr    out  AW  RAM address
//   ram_wdata   out  DW  RAM write data
//   ram_rdata   in   DW  RAM read data, registered, valid 1 cycle after ram_addr
//   busy        out  1   high while a request is in flight (state != IDLE)
//   grant_id    out  1   requester owning the in-flight op (0 when idle)
// BEHAVIOUR
//   - Reset: state=IDLE, rr_ptr=0 (requester 0 preferred). All outputs 0:
//     req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_wdata, busy, grant_id.
//   - FSM states and transitions:
//     - IDLE -> ISSUE when req_valid!=0.
//       - Same cycle: req_ready asserted (combinationally) for the winner only.
//       - Winner's we/addr/wdata and id are registered.
//     - ISSUE, 1 cycle: ram_addr/ram_wdata driven from the latched cmd;
//       ram_we=1 only for writes. Goes to RESP.
//     - RESP, 1 cycle: ram_we=0.
//       - Read: rsp_rdata <= ram_rdata.
//       - rsp_valid[id] pulses for exactly 1 cycle on the cycle after RESP,
//         registered, together with rsp_rdata.
//       - Goes to IDLE.
//   - Latency: accept at cycle T, RAM access at T+1, rsp_valid at T+3.
//     Max throughput is 1 op per 3 cycles.
//   - req_ready is 0 outside IDLE. Requesters hold valid/we/addr/wdata stable until accepted.
//     Dropping valid before acceptance withdraws the request; this is legal.
//   - Arbitration, single valid: that requester wins regardless of rr_ptr.
//   - Arbitration, both valid:
//     - FIXED_PRIO=0: rr_ptr wins, and rr_ptr <= ~winner on every accept.
//     - FIXED_PRIO=1: requester 0 wins and rr_ptr is unused.
//   - No starvation with FIXED_PRIO=0: a continuously valid requester is accepted
//     within 2 grants.
//   - ram_addr/ram_wdata hold the last issued value when not in ISSUE.
//     Only ram_we is qualified.
//   - rsp_rdata returns to 0 the cycle after its rsp_valid pulse.
//     For a write completion it is 0.
//   - Read-after-write to the same address, issued back-to-back: returns the new data,
//     since the write completes in the RAM before the next ISSUE.
//   - Reset mid-operation, in any state: the in-flight op is abandoned.
//     - No rsp_valid is produced.
//     - A write caught in ISSUE may or may not reach RAM; software must rewrite.
//   - Address and data widths are truncated/zero-extended to AW/DW; there is no wrap logic.
// TESTING
//   1. Single write then read, requester 0: write addr=3 data=A, then read addr=3.
//      -> rsp_valid=01 at T+3 for each op; read rsp_rdata=A.
//   2. Simultaneous contention: both valid reads, addr0=1, addr1=2, after reset.
//      -> req0 accepted first, req1 accepted 3 cycles later.
//      -> rsp_valid 01 then 10 with the respective data.
//   3. Round-robin fairness: both held valid for 6 grants.
//      -> grant order 0,1,0,1,0,1.
//      -> Repeat with FIXED_PRIO=1 -> grant order 0,0,0,...
//   4. Isolation: req1 writes addr=5 data=C, then req0 reads addr=5.
//      -> req0 gets C; rsp_valid never has bit 0 set for req1's write.
//   5. Reset in RESP of a read: assert rst one cycle.
//      -> no rsp_valid; busy=0, req_ready=0 next cycle; next request accepted normally.
//   6. Withdrawal and hold: req1 pulses valid while busy and then drops it -> never accepted.
//      While busy -> req_ready stays 00.

Source files
------------

// File: rtl/ram16x4_arbiter_if.sv
// Requester-side bundle for ram16x4_arbiter: two packed request channels and a shared response path.
// Handshake: request i is taken on a rising edge where req_valid[i] & req_ready[i]; rsp_valid is a one-cycle, one-hot completion pulse.
interface ram16x4_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram16x4_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM; one operation is in flight at a time:
// IDLE (accept) -> ISSUE (drive RAM) -> RESP (capture read data) -> IDLE.
module ram16x4_arbiter #(
    parameter int AW         = 4,
    parameter int DW         = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    ram16x4_arbiter_if.slave    bus,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata,
    output logic                busy,
    output logic                grant_id,
    output logic [1:0]          fsm_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;
    logic            winner;
    logic            accept;
    logic            cmd_we;
    logic            cmd_id;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;

    // A lone requester always wins; rr_ptr only breaks ties.
    always_comb begin
        winner = 1'b0;
        case (bus.req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = FIXED_PRIO ? 1'b0 : rr_ptr;
            default: winner = 1'b0;
        endcase
    end

    assign accept = (state == IDLE) && (bus.req_valid != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (accept) req_ready = winner ? 2'b10 : 2'b01;
        ram_we    = (state == ISSUE) && cmd_we;
        busy      = (state != IDLE);
        grant_id  = busy ? cmd_id : 1'b0;
        fsm_state = state;
    end

    // The command registers only change on accept, so the RAM bus holds the last issued op between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept) begin
            if (!FIXED_PRIO) rr_ptr <= ~winner;
            cmd_id    <= winner;
            cmd_we    <= bus.req_we[winner];
            cmd_addr  <= winner ? bus.req_addr[2*AW-1:AW]  : bus.req_addr[AW-1:0];
            cmd_wdata <= winner ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
        end else if (state == RESP) begin
            rsp_valid <= cmd_id ? 2'b10 : 2'b01;
            rsp_rdata <= cmd_we ? '0 : ram_rdata;
        end else begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
        end
    end

    assign ram_addr      = cmd_addr;
    assign ram_wdata     = cmd_wdata;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
endmodule

// File: tb/tb_ram16x4_arbiter.sv
// Directed bench for ram16x4_arbiter: a round-robin instance and a fixed-priority instance, each with its own RAM model.
module tb_ram16x4_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_pass   = 0;

    ram16x4_arbiter_if #(.AW(4), .DW(4)) ifc ();
    ram16x4_arbiter_if #(.AW(4), .DW(4)) fifc ();

    logic       ram_we,   f_ram_we;
    logic [3:0] ram_addr, f_ram_addr;
    logic [3:0] ram_wdata, f_ram_wdata;
    logic [3:0] ram_rdata, f_ram_rdata;
    logic       busy, f_busy;
    logic       grant_id, f_grant_id;
    logic [1:0] fsm_state, f_fsm_state;
    logic [3:0] mem [16];
    logic [3:0] f_mem [16];

    always #5 clk = ~clk;

    ram16x4_arbiter #(.AW(4), .DW(4), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(ifc),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .grant_id(grant_id), .fsm_state(fsm_state)
    );

    ram16x4_arbiter #(.AW(4), .DW(4), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .rst(rst), .bus(fifc),
        .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata),
        .busy(f_busy), .grant_id(f_grant_id), .fsm_state(f_fsm_state)
    );

    // Single-port synchronous RAM models: read data registered one cycle after the address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (f_ram_we) f_mem[f_ram_addr] <= f_ram_wdata;
        f_ram_rdata <= f_mem[f_ram_addr];
    end

    typedef struct {
        bit         ok;
        logic [1:0] rv1, rv2, rv3;
        logic [3:0] rd3, addr1, wdata1;
        logic       we1, we2, busy1, gid1;
    } obs_t;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        ifc.req_valid = 2'b00; fifc.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
    endtask

    // Issue one op on requester r, wait for acceptance (bounded), then record T+1..T+3.
    task automatic run_op(input int r, input logic we, input logic [3:0] addr, input logic [3:0] wdata, output obs_t o);
        @(posedge clk); #1;
        ifc.req_valid[r] = 1'b1;
        ifc.req_we[r] = we;
        ifc.req_addr[r*4 +: 4] = addr;
        ifc.req_wdata[r*4 +: 4] = wdata;
        o.ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (ifc.req_ready[r]) begin o.ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ifc.req_valid[r] = 1'b0;
        #2;
        o.rv1 = ifc.rsp_valid; o.we1 = ram_we; o.addr1 = ram_addr; o.wdata1 = ram_wdata;
        o.busy1 = busy; o.gid1 = grant_id;
        @(posedge clk); #3;
        o.rv2 = ifc.rsp_valid; o.we2 = ram_we;
        @(posedge clk); #3;
        o.rv3 = ifc.rsp_valid; o.rd3 = ifc.rsp_rdata;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (ifc.req_ready !== 2'b00) $display("FAIL reset_ready: got %b exp 00", ifc.req_ready); else n_pass++;
        n_checks++; if (ifc.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b exp 00", ifc.rsp_valid); else n_pass++;
        n_checks++; if (ifc.rsp_rdata !== 4'h0) $display("FAIL reset_rsp_rdata: got %h exp 0", ifc.rsp_rdata); else n_pass++;
        n_checks++; if ({ram_we, ram_addr, ram_wdata} !== 9'h0) $display("FAIL reset_ram_bus: got %h exp 0", {ram_we, ram_addr, ram_wdata}); else n_pass++;
        n_checks++; if ({busy, grant_id, fsm_state} !== 4'h0) $display("FAIL reset_busy_gid_state: got %b exp 0000", {busy, grant_id, fsm_state}); else n_pass++;
    endtask

    task automatic test_write_read();
        obs_t o;
        run_op(0, 1'b1, 4'h3, 4'hA, o);
        n_checks++; if (o.ok !== 1'b1) $display("FAIL wr_accept: got %b exp 1", o.ok); else n_pass++;
        n_checks++; if ({o.we1, o.addr1, o.wdata1} !== 9'h13A) $display("FAIL wr_issue_bus: got %h exp 13a", {o.we1, o.addr1, o.wdata1}); else n_pass++;
        n_checks++; if ({o.busy1, o.gid1, o.we2} !== 3'b100) $display("FAIL wr_busy_gid_we2: got %b exp 100", {o.busy1, o.gid1, o.we2}); else n_pass++;
        n_checks++; if ({o.rv1, o.rv2, o.rv3} !== 6'b000001) $display("FAIL wr_rsp_timing: got %b exp 000001", {o.rv1, o.rv2, o.rv3}); else n_pass++;
        n_checks++; if (o.rd3 !== 4'h0) $display("FAIL wr_rsp_rdata: got %h exp 0", o.rd3); else n_pass++;
        run_op(0, 1'b0, 4'h3, 4'h0, o);
        n_checks++; if (o.we1 !== 1'b0) $display("FAIL rd_ram_we: got %b exp 0", o.we1); else n_pass++;
        n_checks++; if ({o.rv1, o.rv2, o.rv3} !== 6'b000001) $display("FAIL rd_rsp_timing: got %b exp 000001", {o.rv1, o.rv2, o.rv3}); else n_pass++;
        n_checks++; if (o.rd3 !== 4'hA) $display("FAIL rd_rsp_rdata: got %h exp a", o.rd3); else n_pass++;
        @(posedge clk); #3;
        n_checks++; if ({ifc.rsp_valid, ifc.rsp_rdata} !== 6'h0) $display("FAIL rd_rsp_clear: got %h exp 0", {ifc.rsp_valid, ifc.rsp_rdata}); else n_pass++;
        n_checks++; if ({ram_we, ram_addr} !== 5'h03) $display("FAIL ram_addr_hold: got %h exp 03", {ram_we, ram_addr}); else n_pass++;
    endtask

    task automatic test_contention();
        obs_t o;
        run_op(0, 1'b1, 4'h1, 4'h6, o);
        run_op(0, 1'b1, 4'h2, 4'h9, o);
        apply_reset();
        @(posedge clk); #1;
        ifc.req_valid = 2'b11; ifc.req_we = 2'b00; ifc.req_addr = 8'h21;
        #2;
        n_checks++; if (ifc.req_ready !== 2'b01) $display("FAIL cont_first_ready: got %b exp 01", ifc.req_ready); else n_pass++;
        @(posedge clk); #1; ifc.req_valid[0] = 1'b0; #2;
        n_checks++; if ({ifc.req_ready, grant_id} !== 3'b000) $display("FAIL cont_t1_ready_gid: got %b exp 000", {ifc.req_ready, grant_id}); else n_pass++;
        @(posedge clk); #3;
        n_checks++; if (ifc.req_ready !== 2'b00) $display("FAIL cont_t2_ready: got %b exp 00", ifc.req_ready); else n_pass++;
        @(posedge clk); #3;
        n_checks++; if (ifc.req_ready !== 2'b10) $display("FAIL cont_second_ready: got %b exp 10", ifc.req_ready); else n_pass++;
        n_checks++; if ({ifc.rsp_valid, ifc.rsp_rdata} !== 6'b01_0110) $display("FAIL cont_rsp0: got %b exp 010110", {ifc.rsp_valid, ifc.rsp_rdata}); else n_pass++;
        @(posedge clk); #1; ifc.req_valid[1] = 1'b0; #2;
        n_checks++; if ({grant_id, ifc.rsp_valid} !== 3'b100) $display("FAIL cont_gid1: got %b exp 100", {grant_id, ifc.rsp_valid}); else n_pass++;
        @(posedge clk);
        @(posedge clk); #3;
        n_checks++; if ({ifc.rsp_valid, ifc.rsp_rdata} !== 6'b10_1001) $display("FAIL cont_rsp1: got %b exp 101001", {ifc.rsp_valid, ifc.rsp_rdata}); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] rr_q[$];
        logic [1:0] fx_q[$];
        logic [1:0] exp_rr, got;
        apply_reset();
        @(posedge clk); #1;
        ifc.req_valid = 2'b11;  ifc.req_we = 2'b00;  ifc.req_addr = 8'h54;
        fifc.req_valid = 2'b11; fifc.req_we = 2'b00; fifc.req_addr = 8'h54;
        for (int c = 0; c < 18; c++) begin
            #2;
            if (ifc.req_ready != 2'b00) rr_q.push_back(ifc.req_ready);
            if (fifc.req_ready != 2'b00) fx_q.push_back(fifc.req_ready);
            @(posedge clk); #1;
        end
        ifc.req_valid = 2'b00; fifc.req_valid = 2'b00;
        n_checks++; if (rr_q.size() !== 6) $display("FAIL rr_grant_count: got %0d exp 6", rr_q.size()); else n_pass++;
        n_checks++; if (fx_q.size() !== 6) $display("FAIL fixed_grant_count: got %0d exp 6", fx_q.size()); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            exp_rr = (k % 2 == 0) ? 2'b01 : 2'b10;
            got = (k < rr_q.size()) ? rr_q[k] : 2'bxx;
            n_checks++; if (got !== exp_rr) $display("FAIL rr_grant_%0d: got %b exp %b", k, got, exp_rr); else n_pass++;
            got = (k < fx_q.size()) ? fx_q[k] : 2'bxx;
            n_checks++; if (got !== 2'b01) $display("FAIL fixed_grant_%0d: got %b exp 01", k, got); else n_pass++;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_isolation();
        obs_t o;
        apply_reset();
        run_op(1, 1'b1, 4'h5, 4'hC, o);
        n_checks++; if (o.ok !== 1'b1) $display("FAIL iso_wr_accept: got %b exp 1", o.ok); else n_pass++;
        n_checks++; if (o.gid1 !== 1'b1) $display("FAIL iso_wr_gid: got %b exp 1", o.gid1); else n_pass++;
        n_checks++; if ({o.rv1, o.rv2, o.rv3} !== 6'b000010) $display("FAIL iso_wr_rsp: got %b exp 000010", {o.rv1, o.rv2, o.rv3}); else n_pass++;
        run_op(0, 1'b0, 4'h5, 4'h0, o);
        n_checks++; if ({o.rv3, o.rd3} !== 6'b01_1100) $display("FAIL iso_rd_rsp: got %b exp 011100", {o.rv3, o.rd3}); else n_pass++;
    endtask

    task automatic test_reset_in_resp();
        obs_t o;
        apply_reset();
        run_op(0, 1'b1, 4'h3, 4'h6, o);
        @(posedge clk); #1;
        ifc.req_valid[0] = 1'b1; ifc.req_we[0] = 1'b0; ifc.req_addr[3:0] = 4'h3;
        #2;
        n_checks++; if (ifc.req_ready !== 2'b01) $display("FAIL rir_accept: got %b exp 01", ifc.req_ready); else n_pass++;
        @(posedge clk); #1; ifc.req_valid[0] = 1'b0;
        @(posedge clk); #1; rst = 1'b1; #2;
        n_checks++; if ({busy, fsm_state} !== 3'b110) $display("FAIL rir_in_resp: got %b exp 110", {busy, fsm_state}); else n_pass++;
        @(posedge clk); #1; rst = 1'b0; #2;
        n_checks++; if ({ifc.rsp_valid, ifc.rsp_rdata} !== 6'h0) $display("FAIL rir_no_rsp: got %h exp 0", {ifc.rsp_valid, ifc.rsp_rdata}); else n_pass++;
        n_checks++; if ({busy, ifc.req_ready} !== 3'b000) $display("FAIL rir_idle: got %b exp 000", {busy, ifc.req_ready}); else n_pass++;
        @(posedge clk); #3;
        n_checks++; if (ifc.rsp_valid !== 2'b00) $display("FAIL rir_no_late_rsp: got %b exp 00", ifc.rsp_valid); else n_pass++;
        run_op(0, 1'b0, 4'h3, 4'h0, o);
        n_checks++; if ({o.ok, o.rv3, o.rd3} !== 7'b1_01_0110) $display("FAIL rir_recover: got %b exp 1010110", {o.ok, o.rv3, o.rd3}); else n_pass++;
    endtask

    task automatic test_withdraw();
        apply_reset();
        @(posedge clk); #1;
        ifc.req_valid[0] = 1'b1; ifc.req_we[0] = 1'b1; ifc.req_addr[3:0] = 4'h7; ifc.req_wdata[3:0] = 4'h5;
        #2;
        n_checks++; if (ifc.req_ready !== 2'b01) $display("FAIL wd_accept0: got %b exp 01", ifc.req_ready); else n_pass++;
        @(posedge clk); #1;
        ifc.req_valid = 2'b10; ifc.req_we[1] = 1'b0; ifc.req_addr[7:4] = 4'h7;
        #2;
        n_checks++; if ({busy, ifc.req_ready} !== 3'b100) $display("FAIL wd_busy_ready_t1: got %b exp 100", {busy, ifc.req_ready}); else n_pass++;
        @(posedge clk); #1; ifc.req_valid[1] = 1'b0; #2;
        n_checks++; if (ifc.req_ready !== 2'b00) $display("FAIL wd_ready_t2: got %b exp 00", ifc.req_ready); else n_pass++;
        @(posedge clk); #3;
        n_checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.rsp_rdata} !== 8'b00_01_0000) $display("FAIL wd_t3: got %b exp 00010000", {ifc.req_ready, ifc.rsp_valid, ifc.rsp_rdata}); else n_pass++;
        @(posedge clk); #3;
        n_checks++; if ({busy, grant_id, ifc.rsp_valid} !== 4'b0000) $display("FAIL wd_never_accepted: got %b exp 0000", {busy, grant_id, ifc.rsp_valid}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(posedge clk); #1;
        ifc.req_valid[0] = 1'b1; ifc.req_we[0] = 1'b1; ifc.req_addr[3:0] = 4'h9; ifc.req_wdata[3:0] = 4'hD;
        #2;
        n_checks++; if (ifc.req_ready !== 2'b01) $display("FAIL b2b_wr_accept: got %b exp 01", ifc.req_ready); else n_pass++;
        @(posedge clk); #1; ifc.req_we[0] = 1'b0; #2;
        n_checks++; if ({ram_we, ram_addr, ram_wdata} !== 9'h19D) $display("FAIL b2b_wr_issue: got %h exp 19d", {ram_we, ram_addr, ram_wdata}); else n_pass++;
        @(posedge clk);
        @(posedge clk); #3;
        n_checks++; if ({ifc.req_ready, ifc.rsp_valid} !== 4'b0101) $display("FAIL b2b_rd_accept: got %b exp 0101", {ifc.req_ready, ifc.rsp_valid}); else n_pass++;
        @(posedge clk); #1; ifc.req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        n_checks++; if ({ifc.rsp_valid, ifc.rsp_rdata} !== 6'b01_1101) $display("FAIL b2b_raw_data: got %b exp 011101", {ifc.rsp_valid, ifc.rsp_rdata}); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mem[i] = 4'h0; f_mem[i] = 4'h0; end
        ifc.req_valid = 2'b00; ifc.req_we = 2'b00; ifc.req_addr = 8'h00; ifc.req_wdata = 8'h00;
        fifc.req_valid = 2'b00; fifc.req_we = 2'b00; fifc.req_addr = 8'h00; fifc.req_wdata = 8'h00;
        test_reset();
        test_write_read();
        test_contention();
        test_round_robin();
        test_isolation();
        test_reset_in_resp();
        test_withdraw();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
